// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the unified memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [2:0] {
    LDST_LB  = 3'b000,
    LDST_LH  = 3'b001,
    LDST_LW  = 3'b010,
    LDST_LBU = 3'b011,
    LDST_LHU = 3'b100,
    LDST_SB  = 3'b101,
    LDST_SH  = 3'b110,
    LDST_SW  = 3'b111
  } ldst_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RD, ST_DONE} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;
  function automatic logic is_store(input ldst_e op);
    return op inside {LDST_SB, LDST_SH, LDST_SW};
  endfunction
  function automatic logic is_misaligned(input ldst_e op, input logic [1:0] o);
    return (op inside {LDST_LH, LDST_LHU, LDST_SH} && o[0]) || (op inside {LDST_LW, LDST_SW} && o != 2'b00);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_ldst_lane.sv
// ldst_lane: byte enables, store lane replication and load extension for one access
module ldst_lane
  import mem_port_arbiter_pkg::*;
(
  input  ldst_e       op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  assign rbyte = rdata[{off, 3'b000} +: 8];
  assign rhalf = off[1] ? rdata[31:16] : rdata[15:0];
  assign be = op == LDST_SB ? 4'b0001 << off :
              op == LDST_SH ? (off[1] ? 4'b1100 : 4'b0011) :
              op == LDST_SW ? 4'b1111 : 4'b0000;
  assign wdata_rep = op == LDST_SB ? {4{wdata[7:0]}} :
                     op == LDST_SH ? {2{wdata[15:0]}} : wdata;
  assign rdata_ext = op == LDST_LB  ? {{24{rbyte[7]}}, rbyte} :
                     op == LDST_LBU ? {24'b0, rbyte} :
                     op == LDST_LH  ? {{16{rhalf[15]}}, rhalf} :
                     op == LDST_LHU ? {16'b0, rhalf} : rdata;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store traffic
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4,
  parameter int RUN_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [2:0]  d_ldst,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_misalign,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  ldst_e ldst_q, ldst_d;
  logic [1:0] off_q, off_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic mem_req_valid_q, mem_req_valid_d, if_done_q, if_done_d;
  logic d_done_q, d_done_d, d_misalign_q, d_misalign_d;
  logic [3:0] mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  ldst_e lane_op;
  logic [1:0] lane_off;
  logic [3:0] lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic d_win, f_win;
  // The lane decodes the live request while arbitrating and the latched access afterwards
  assign lane_op = state_q == ST_IDLE ? ldst_e'(d_ldst) : ldst_q;
  assign lane_off = state_q == ST_IDLE ? d_addr[1:0] : off_q;
  ldst_lane u_lane (
    .op(lane_op),
    .off(lane_off),
    .wdata(d_wdata),
    .rdata(mem_rdata),
    .be(lane_be),
    .wdata_rep(lane_wdata),
    .rdata_ext(lane_rdata)
  );
  assign d_win = d_req & ~(if_req & (run_q == RUN_W'(MAX_DATA_RUN)));
  assign f_win = if_req & ~d_win;
  // Next-state and next-output logic for the single-outstanding-transaction sequencer
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ldst_d = ldst_q;
    off_d = off_q;
    run_d = run_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d = mem_addr_q;
    mem_we_d = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    if_done_d = 1'b0;
    d_done_d = 1'b0;
    d_misalign_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        run_d = (if_req & d_win) ? run_q + 1'b1 : '0;
        if (d_win & is_misaligned(ldst_e'(d_ldst), d_addr[1:0])) begin
          state_d = ST_DONE;
          d_done_d = 1'b1;
          d_misalign_d = 1'b1;
        end else if (d_win | f_win) begin
          state_d = ST_ISSUE;
          owner_d = d_win ? OWN_D : OWN_IF;
          ldst_d = d_win ? ldst_e'(d_ldst) : LDST_LW;
          off_d = d_win ? d_addr[1:0] : 2'b00;
          mem_req_valid_d = 1'b1;
          mem_addr_d = (d_win ? d_addr : if_addr) & ~32'h3;
          mem_we_d = d_win ? lane_be : 4'b0000;
          mem_wdata_d = d_win ? lane_wdata : '0;
        end
      end
      ST_ISSUE: if (mem_req_ready) begin
        mem_req_valid_d = 1'b0;
        state_d = is_store(ldst_q) ? ST_DONE : ST_WAIT_RD;
        d_done_d = is_store(ldst_q);
      end
      ST_WAIT_RD: if (mem_rvalid) begin
        state_d = ST_DONE;
        if_done_d = owner_q == OWN_IF;
        d_done_d = owner_q == OWN_D;
        if_rdata_d = owner_q == OWN_IF ? mem_rdata : if_rdata_q;
        d_rdata_d = owner_q == OWN_D ? lane_rdata : d_rdata_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // State and registered outputs; reset drops any in-flight transaction silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      ldst_q <= LDST_LB;
      off_q <= 2'b00;
      run_q <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q <= '0;
      mem_wdata_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
      if_done_q <= 1'b0;
      d_done_q <= 1'b0;
      d_misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ldst_q <= ldst_d;
      off_q <= off_d;
      run_q <= run_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
      if_done_q <= if_done_d;
      d_done_q <= d_done_d;
      d_misalign_q <= d_misalign_d;
    end
  end
  assign if_done = if_done_q;
  assign if_rdata = if_rdata_q;
  assign d_done = d_done_q;
  assign d_rdata = d_rdata_q;
  assign d_misalign = d_misalign_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr = mem_addr_q;
  assign mem_we = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if = if_req & ~if_done_q;
  assign stall_mem = d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench with a behavioural memory and access model
module tb_mem_port_arbiter;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;
  typedef struct {logic [31:0] addr; logic [3:0] we; logic [31:0] wdata;} hs_t;
  logic clk = 1'b0;
  logic rst_n, if_req, if_done, d_req, d_done, d_misalign, stall_if, stall_mem;
  logic mem_req_valid, mem_req_ready, mem_rvalid;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0] d_ldst;
  logic [3:0] mem_we;
  logic mdl_ready, mdl_rvalid, force_rvalid, ready_block, rd_suppress, rand_mode, fixed_en;
  logic [31:0] mdl_rdata, force_rdata, fixed_word;
  hs_t hs_q[$];
  int checks = 0, errors = 0;

  assign mem_req_ready = mdl_ready & ~ready_block;
  assign mem_rvalid = mdl_rvalid | force_rvalid;
  assign mem_rdata = force_rvalid ? force_rdata : mdl_rdata;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_ldst(d_ldst), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_misalign(d_misalign),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return fixed_en ? fixed_word : ((a & ~32'h3) * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
  endfunction
  function automatic int sz(input logic [2:0] op);
    return (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
  endfunction
  function automatic bit ref_mis(input logic [2:0] op, input logic [31:0] a);
    return (a % sz(op)) != 0;
  endfunction
  function automatic logic [3:0] ref_we(input logic [2:0] op, input logic [31:0] a);
    return op >= SB ? 4'(((1 << sz(op)) - 1) << (a % 4)) : 4'b0000;
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(wd >> (8 * (i % sz(op))));
    return w;
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] word);
    logic [63:0] mask, v;
    mask = (64'd1 << (8 * sz(op))) - 1;
    v = (64'(word) >> (8 * (a % 4))) & mask;
    if ((op == LB || op == LH) && v[8 * sz(op) - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Memory responder: records each handshake and returns read data after a delay
  initial begin : mem_model
    hs_t rec;
    logic hs_prev, rd_pend;
    int rd_cnt;
    logic [31:0] rd_addr;
    hs_prev = 0; rd_pend = 0; rd_cnt = 0; rd_addr = 0;
    rec = '{32'h0, 4'h0, 32'h0};
    mdl_ready = 1; mdl_rvalid = 0; mdl_rdata = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        hs_prev = 0; rd_pend = 0; mdl_rvalid = 0;
      end else begin
        mdl_rvalid = 0;
        if (hs_prev) begin
          hs_q.push_back(rec);
          if (rec.we == 4'b0) begin
            rd_pend = 1; rd_addr = rec.addr;
            rd_cnt = rand_mode ? int'($urandom_range(0, 2)) : 0;
          end
        end
        if (rd_pend && !rd_suppress) begin
          if (rd_cnt == 0) begin mdl_rvalid = 1; mdl_rdata = word_at(rd_addr); rd_pend = 0; end
          else rd_cnt--;
        end
        mdl_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        hs_prev = mem_req_valid & mdl_ready & ~ready_block;
        rec = '{mem_addr, mem_we, mem_wdata};
      end
    end
  end

  task automatic run_data(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output logic done, output logic mis, output logic [31:0] rd,
                          output int n, output logic saw_valid);
    done = 0; mis = 0; rd = 0; n = 0; saw_valid = 0;
    @(negedge clk);
    d_req = 1; d_ldst = op; d_addr = a; d_wdata = wd;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      saw_valid = saw_valid | mem_req_valid;
      if (d_done) begin done = 1; mis = d_misalign; rd = d_rdata; end
    end
    d_req = 0;
    @(negedge clk);
  endtask

  task automatic run_fetch(input logic [31:0] a, output logic done, output logic [31:0] rd, output int n);
    done = 0; rd = 0; n = 0;
    @(negedge clk);
    if_req = 1; if_addr = a;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (if_done) begin done = 1; rd = if_rdata; end
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if ({if_done, d_done, d_misalign, mem_req_valid} !== 4'b0) begin errors++; $display("FAIL reset_hold strobes got %b exp 0000", {if_done, d_done, d_misalign, mem_req_valid}); end
    rst_n = 1;
    @(negedge clk); force_rvalid = 1; force_rdata = 32'hFFFF_FFFF;
    @(negedge clk); force_rvalid = 0;
    @(negedge clk);
    checks++; if ({if_done, d_done, d_misalign, mem_req_valid, stall_if, stall_mem} !== 6'b0) begin errors++; $display("FAIL reset_strobes got %b exp 000000", {if_done, d_done, d_misalign, mem_req_valid, stall_if, stall_mem}); end
    checks++; if (mem_we !== 4'b0) begin errors++; $display("FAIL reset_we got %b exp 0000", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata got %h exp 0", if_rdata); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata got %h exp 0", d_rdata); end
  endtask

  task automatic test_load_ext();
    logic done, mis, sv;
    logic [31:0] rd;
    int n;
    fixed_en = 1; fixed_word = 32'h80FF_1234;
    hs_q.delete();
    run_data(LB, 32'h103, 32'h0, done, mis, rd, n, sv);
    checks++; if (!done || rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_ext done %b got %h exp ffffff80", done, rd); end
    checks++; if (n != 3) begin errors++; $display("FAIL lb_latency got %0d exp 3", n); end
    checks++; if (hs_q.size() != 1 || hs_q[0].addr !== 32'h100 || hs_q[0].we !== 4'b0) begin errors++; $display("FAIL lb_req n %0d", hs_q.size()); end
    run_data(LBU, 32'h103, 32'h0, done, mis, rd, n, sv);
    checks++; if (!done || rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_ext done %b got %h exp 00000080", done, rd); end
    run_data(LH, 32'h102, 32'h0, done, mis, rd, n, sv);
    checks++; if (!done || rd !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_ext done %b got %h exp ffff80ff", done, rd); end
    run_data(LHU, 32'h100, 32'h0, done, mis, rd, n, sv);
    checks++; if (!done || rd !== 32'h0000_1234) begin errors++; $display("FAIL lhu_ext done %b got %h exp 00001234", done, rd); end
    fixed_en = 0;
  endtask

  task automatic test_store_sh();
    logic done, mis, sv;
    logic [31:0] rd;
    int n;
    hs_q.delete();
    run_data(SH, 32'h202, 32'h0000_BEEF, done, mis, rd, n, sv);
    checks++; if (!done || n != 2) begin errors++; $display("FAIL sh_latency done %b got %0d exp 2", done, n); end
    checks++; if (hs_q.size() != 1 || hs_q[0].addr !== 32'h200 || hs_q[0].we !== 4'b1100 || hs_q[0].wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_req n %0d exp addr 200 we 1100 wdata beefbeef", hs_q.size()); end
  endtask

  task automatic test_misalign();
    logic done, mis, sv;
    logic [31:0] rd;
    int n;
    logic [2:0] ops[4] = '{SW, LH, LW, SH};
    logic [31:0] adrs[4] = '{32'h301, 32'h101, 32'h102, 32'h203};
    for (int i = 0; i < 4; i++) begin
      hs_q.delete();
      run_data(ops[i], adrs[i], 32'h1234_5678, done, mis, rd, n, sv);
      checks++; if (!done || !mis || sv || hs_q.size() != 0) begin errors++; $display("FAIL misalign_%0d done %b mis %b valid %b reqs %0d exp 1 1 0 0", i, done, mis, sv, hs_q.size()); end
    end
  endtask

  task automatic test_fairness();
    int dones, n, run;
    bit exp_if;
    logic [31:0] exp_a;
    hs_q.delete();
    dones = 0; n = 0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h0001_0000; d_req = 1; d_ldst = LW; d_addr = 32'h40;
    while (dones < 15 && n < 400) begin
      @(negedge clk);
      n++;
      if (if_done | d_done) dones++;
    end
    if_req = 0; d_req = 0;
    repeat (2) @(negedge clk);
    checks++; if (dones != 15 || hs_q.size() != 15) begin errors++; $display("FAIL fair_count dones %0d reqs %0d exp 15 15", dones, hs_q.size()); end
    run = 0;
    for (int i = 0; i < 15; i++) begin
      exp_if = run == 4;
      run = exp_if ? 0 : run + 1;
      exp_a = exp_if ? 32'h0001_0000 : 32'h40;
      checks++; if (i >= hs_q.size() || hs_q[i].addr !== exp_a) begin errors++; $display("FAIL fair_grant_%0d got %h exp %h", i, i < hs_q.size() ? hs_q[i].addr : 32'hx, exp_a); end
    end
  endtask

  task automatic test_ready_stall();
    logic done, stall_bad;
    logic [31:0] rd;
    int n;
    @(posedge clk); #1 ready_block = 1;
    @(negedge clk); if_req = 1; if_addr = 32'h0001_0104;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0001_0104 || stall_if !== 1'b1) begin errors++; $display("FAIL hold_%0d valid %b addr %h stall %b exp 1 00010104 1", i, mem_req_valid, mem_addr, stall_if); end
    end
    @(posedge clk); #1 ready_block = 0;
    done = 0; rd = 0; n = 0; stall_bad = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (if_done) begin done = 1; rd = if_rdata; stall_bad = stall_bad | stall_if; end
      else stall_bad = stall_bad | ~stall_if;
    end
    if_req = 0;
    checks++; if (!done || stall_bad) begin errors++; $display("FAIL stall_if done %b stall_err %b exp 1 0", done, stall_bad); end
    checks++; if (rd !== word_at(32'h0001_0104)) begin errors++; $display("FAIL stall_rdata got %h exp %h", rd, word_at(32'h0001_0104)); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic done, mis, sv, bad;
    logic [31:0] rd;
    int n;
    rd_suppress = 1; hs_q.delete();
    @(negedge clk); d_req = 1; d_ldst = LW; d_addr = 32'h80; d_wdata = 0;
    n = 0;
    while (hs_q.size() == 0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (hs_q.size() != 1) begin errors++; $display("FAIL rstmid_issue reqs %0d exp 1", hs_q.size()); end
    #1 rst_n = 0; d_req = 0;
    #2 rst_n = 1; rd_suppress = 0;
    bad = 0;
    @(negedge clk); bad = bad | if_done | d_done | mem_req_valid; force_rvalid = 1; force_rdata = 32'h1357_9BDF;
    @(negedge clk); bad = bad | if_done | d_done | mem_req_valid; force_rvalid = 0;
    repeat (3) begin @(negedge clk); bad = bad | if_done | d_done | mem_req_valid; end
    checks++; if (bad !== 1'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_stale activity %b d_rdata %h exp 0 0", bad, d_rdata); end
    hs_q.delete();
    run_data(LW, 32'h84, 32'h0, done, mis, rd, n, sv);
    checks++; if (!done || rd !== word_at(32'h84) || n != 3) begin errors++; $display("FAIL rstmid_next done %b got %h lat %0d exp %h lat 3", done, rd, n, word_at(32'h84)); end
  endtask

  task automatic test_random();
    logic done, mis, sv;
    logic [31:0] rd, a, wd;
    logic [2:0] op;
    int n;
    @(posedge clk); #1 rand_mode = 1;
    for (int it = 0; it < 40; it++) begin
      hs_q.delete();
      if ($urandom_range(0, 3) == 0) begin
        a = {16'h0002, 14'($urandom), 2'b00};
        run_fetch(a, done, rd, n);
        checks++; if (!done || rd !== word_at(a)) begin errors++; $display("FAIL rnd_fetch_%0d done %b got %h exp %h", it, done, rd, word_at(a)); end
        checks++; if (hs_q.size() != 1 || hs_q[0].addr !== a || hs_q[0].we !== 4'b0) begin errors++; $display("FAIL rnd_fetch_req_%0d reqs %0d exp addr %h", it, hs_q.size(), a); end
      end else begin
        op = 3'($urandom_range(0, 7)); a = {16'h0000, 16'($urandom)}; wd = $urandom;
        run_data(op, a, wd, done, mis, rd, n, sv);
        checks++; if (!done || mis !== ref_mis(op, a)) begin errors++; $display("FAIL rnd_done_%0d op %0d addr %h done %b mis %b exp 1 %b", it, op, a, done, mis, ref_mis(op, a)); end
        if (ref_mis(op, a)) begin
          checks++; if (sv || hs_q.size() != 0) begin errors++; $display("FAIL rnd_mis_quiet_%0d valid %b reqs %0d exp 0 0", it, sv, hs_q.size()); end
        end else begin
          checks++; if (hs_q.size() != 1 || hs_q[0].addr !== (a & ~32'h3) || hs_q[0].we !== ref_we(op, a) || (op >= SB && hs_q[0].wdata !== ref_wdata(op, wd))) begin errors++; $display("FAIL rnd_req_%0d op %0d addr %h reqs %0d exp we %b wdata %h", it, op, a, hs_q.size(), ref_we(op, a), ref_wdata(op, wd)); end
          if (op < SB) begin
            checks++; if (rd !== ref_load(op, a, word_at(a))) begin errors++; $display("FAIL rnd_load_%0d op %0d addr %h got %h exp %h", it, op, a, rd, ref_load(op, a, word_at(a))); end
          end
        end
      end
    end
    @(posedge clk); #1 rand_mode = 0;
  endtask

  initial begin
    rst_n = 0; if_req = 0; if_addr = 0; d_req = 0; d_ldst = 0; d_addr = 0; d_wdata = 0;
    force_rvalid = 0; force_rdata = 0; ready_block = 0; rd_suppress = 0; rand_mode = 0;
    fixed_en = 0; fixed_word = 0;
    test_reset();
    test_load_ext();
    test_store_sh();
    test_misalign();
    test_fairness();
    test_ready_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end
endmodule
